// File: rtl/ws2812_led_driver_if.sv
// Framebuffer/vsync input bundle and WS2812 line status for the LED strip driver.
interface ws2812_led_driver_if #(
  parameter int NLEDS = 60
);
  logic                  frame_vsync;
  logic [NLEDS*24-1:0]   framebuffer;
  logic                  led_dout;
  logic                  busy;
  logic                  frame_done;

  modport master (
    output frame_vsync, framebuffer,
    input  led_dout, busy, frame_done
  );

  modport slave (
    input  frame_vsync, framebuffer,
    output led_dout, busy, frame_done
  );
endinterface

// File: rtl/ws2812_led_driver.sv
// Snapshots the averaged colour framebuffer on each vsync rise and serialises it
// onto one WS2812 data line (NRZ bits, GRB MSB first, LED 0 first), then holds the latch gap.
//
// state   | meaning
// IDLE    | line low, waiting for a vsync rising edge
// LOAD    | copy framebuffer into shadow, clear counters
// HIGH    | high part of the current bit (T0H or T1H clocks)
// LOW     | remainder of the bit period up to TBIT clocks
// RESET   | latch gap; frame_done pulses on the exit edge
module ws2812_led_driver #(
  parameter int NLEDS = 60,
  parameter int T0H   = 30,
  parameter int T1H   = 59,
  parameter int TBIT  = 93,
  parameter int TRES  = 22275
) (
  input  logic                   clk_pixel,
  input  logic                   rst_n,
  ws2812_led_driver_if.slave     bus
);

  localparam int TMAX   = (TBIT > TRES) ? TBIT : TRES;
  localparam int TICK_W = $clog2(TMAX + 1);
  localparam int LED_W  = (NLEDS > 1) ? $clog2(NLEDS) : 1;

  localparam logic [TICK_W-1:0] T0H_END  = TICK_W'(T0H - 1);
  localparam logic [TICK_W-1:0] T1H_END  = TICK_W'(T1H - 1);
  localparam logic [TICK_W-1:0] TBIT_END = TICK_W'(TBIT - 1);
  // led_dout lags the state by one clock, so the gap state runs one extra cycle
  // to give exactly TRES low clocks on the line before frame_done.
  localparam logic [TICK_W-1:0] TRES_END = TICK_W'(TRES);
  localparam logic [LED_W-1:0]  LED_LAST = LED_W'(NLEDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HIGH,
    S_LOW,
    S_RESET
  } state_t;

  state_t                    state_q, state_d;
  logic [TICK_W-1:0]         tick_q, tick_d;
  logic [4:0]                bit_cnt_q, bit_cnt_d;
  logic [LED_W-1:0]          led_cnt_q, led_cnt_d;
  logic [NLEDS-1:0][23:0]    shadow_q, shadow_d;
  logic                      vsync_dly_q, vsync_dly_d;
  logic                      led_dout_q, led_dout_d;
  logic                      frame_done_q, frame_done_d;

  logic                      start;
  logic [23:0]               slot;
  logic                      cur_bit;
  logic [TICK_W-1:0]         high_end;

  assign start    = bus.frame_vsync & ~vsync_dly_q;
  assign slot     = shadow_q[led_cnt_q];
  // bytes are stored {B,R,G} but sent G,R,B: byte index = bit_cnt/8, bit = 7 - bit_cnt%8
  assign cur_bit  = slot[{bit_cnt_q[4:3], ~bit_cnt_q[2:0]}];
  assign high_end = cur_bit ? T1H_END : T0H_END;

  always_comb begin
    state_d      = state_q;
    tick_d       = tick_q;
    bit_cnt_d    = bit_cnt_q;
    led_cnt_d    = led_cnt_q;
    shadow_d     = shadow_q;
    vsync_dly_d  = bus.frame_vsync;
    led_dout_d   = (state_q == S_HIGH);
    frame_done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        shadow_d  = bus.framebuffer;
        tick_d    = '0;
        bit_cnt_d = '0;
        led_cnt_d = '0;
        state_d   = S_HIGH;
      end
      S_HIGH: begin
        tick_d = tick_q + TICK_W'(1);
        if (tick_q == high_end) state_d = S_LOW;
      end
      S_LOW: begin
        if (tick_q == TBIT_END) begin
          tick_d = '0;
          if (bit_cnt_q == 5'd23 && led_cnt_q == LED_LAST) begin
            state_d = S_RESET;
          end else begin
            if (bit_cnt_q == 5'd23) begin
              bit_cnt_d = '0;
              led_cnt_d = led_cnt_q + LED_W'(1);
            end else begin
              bit_cnt_d = bit_cnt_q + 5'd1;
            end
            state_d = S_HIGH;
          end
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      S_RESET: begin
        if (tick_q == TRES_END) begin
          tick_d       = '0;
          frame_done_d = 1'b1;
          state_d      = S_IDLE;
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      tick_q       <= '0;
      bit_cnt_q    <= '0;
      led_cnt_q    <= '0;
      shadow_q     <= '0;
      vsync_dly_q  <= 1'b0;
      led_dout_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_q       <= tick_d;
      bit_cnt_q    <= bit_cnt_d;
      led_cnt_q    <= led_cnt_d;
      shadow_q     <= shadow_d;
      vsync_dly_q  <= vsync_dly_d;
      led_dout_q   <= led_dout_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.led_dout   = led_dout_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_ws2812_led_driver.sv
// Bench for ws2812_led_driver: frame-level reference model checked every cycle,
// plus directed pulse-width / frame-length checks with shortened timing parameters.
module tb_ws2812_led_driver;

  localparam int NL    = 4;
  localparam int T0    = 3;
  localparam int T1    = 6;
  localparam int TB    = 9;
  localparam int TR    = 20;
  localparam int FBW   = NL * 24;
  localparam int NBITS = NL * 24;
  // cycles from the start edge E to the frame_done edge
  localparam int L     = 2 + NBITS * TB + TR;

  logic clk_pixel = 1'b0;
  logic rst_n     = 1'b0;

  ws2812_led_driver_if #(.NLEDS(NL)) bus ();

  ws2812_led_driver #(
    .NLEDS(NL), .T0H(T0), .T1H(T1), .TBIT(TB), .TRES(TR)
  ) dut (
    .clk_pixel (clk_pixel),
    .rst_n     (rst_n),
    .bus       (bus)
  );

  always #5 clk_pixel = ~clk_pixel;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: position within the frame counted from the start edge.
  bit             m_active;
  bit             m_prev;
  bit             m_done;
  int             m_n;
  logic [FBW-1:0] m_shadow;

  always @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0; m_prev = 0; m_done = 0; m_n = 0; m_shadow = '0;
    end else begin
      m_done = 0;
      if (m_active) begin
        m_n++;
        if (m_n == 1) m_shadow = bus.framebuffer;
        if (m_n == L) begin
          m_active = 0;
          m_done   = 1;
        end
      end else if (bus.frame_vsync && !m_prev) begin
        m_active = 1;
        m_n      = 0;
      end
      m_prev = bus.frame_vsync;
    end
  end

  function automatic logic model_led();
    int p, k, ph;
    logic [23:0] s, grb;
    logic b;
    if (!m_active || m_n < 2 || m_n >= 2 + NBITS * TB) return 1'b0;
    p   = m_n - 2;
    k   = p / TB;
    ph  = p % TB;
    s   = m_shadow[(k / 24) * 24 +: 24];
    grb = {s[7:0], s[15:8], s[23:16]};
    b   = grb[23 - (k % 24)];
    return (ph < (b ? T1 : T0));
  endfunction

  always @(negedge clk_pixel) begin
    if (rst_n) begin
      chk("led_dout", bus.led_dout, model_led());
      chk("busy", bus.busy, m_active);
      chk("frame_done", bus.frame_done, m_done);
    end
  end

  // Waveform recorder: high-pulse widths, rise times and frame_done times.
  longint cyc = 0;
  int     cur_w = 0;
  int     widths[$];
  longint rise_q[$];
  longint done_q[$];

  always @(negedge clk_pixel) begin
    cyc++;
    if (!rst_n) begin
      cur_w = 0;
    end else begin
      if (bus.led_dout) begin
        if (cur_w == 0) rise_q.push_back(cyc);
        cur_w++;
      end else if (cur_w > 0) begin
        widths.push_back(cur_w);
        cur_w = 0;
      end
      if (bus.frame_done) done_q.push_back(cyc);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_pixel);
  endtask

  task automatic rand_fb(output logic [FBW-1:0] v);
    for (int i = 0; i < FBW / 32; i++) v[i*32 +: 32] = $urandom();
  endtask

  task automatic start_frame();
    bus.frame_vsync = 1'b1;
    cycles(3);
    bus.frame_vsync = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int base;
    int k;
    base = done_q.size();
    k = 0;
    while (done_q.size() == base && k < budget) begin
      @(negedge clk_pixel);
      k++;
    end
    chk({name, "_done_seen"}, (done_q.size() > base) ? 1 : 0, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int wb, rb, db, nb, ones, k;
    logic [FBW-1:0] fa;
    logic [23:0]    pat;

    bus.frame_vsync = 1'b0;
    bus.framebuffer = '0;
    rst_n = 1'b0;
    cycles(5);
    chk("rst_led", bus.led_dout, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.frame_done, 0);
    rst_n = 1'b1;
    cycles(1000);
    chk("idle_busy", bus.busy, 0);

    // all-zero frame
    wb = widths.size(); rb = rise_q.size(); db = done_q.size();
    start_frame();
    wait_done("zero", 1200);
    cycles(5);
    chk("zero_pulses", widths.size() - wb, 96);
    nb = 0;
    for (int i = wb; i < widths.size(); i++) if (widths[i] != T0) nb++;
    chk("zero_bad_widths", nb, 0);
    chk("zero_frame_len", done_q[db] - rise_q[rb], 884);

    // colour ordering
    bus.framebuffer = '0;
    bus.framebuffer[23:0] = 24'h01_80_F0;
    pat = 24'b11110000_10000000_00000001;
    wb = widths.size();
    start_frame();
    wait_done("colour", 1200);
    cycles(5);
    for (int i = 0; i < 24; i++) chk("colour_bit_width", widths[wb + i], pat[23 - i] ? 6 : 3);

    // snapshot: framebuffer changes right after the capture edge
    rand_fb(fa);
    bus.framebuffer = fa;
    wb = widths.size();
    bus.frame_vsync = 1'b1;
    @(posedge clk_pixel);
    @(posedge clk_pixel);
    #1 bus.framebuffer = '1;
    @(negedge clk_pixel);
    bus.frame_vsync = 1'b0;
    wait_done("snap", 1200);
    cycles(5);
    ones = 0;
    for (int i = wb; i < widths.size(); i++) if (widths[i] == T1) ones++;
    chk("snap_ones", ones, $countones(fa));
    chk("snap_pulses", widths.size() - wb, 96);

    // second vsync mid-transfer is dropped
    rand_fb(fa);
    bus.framebuffer = fa;
    wb = widths.size(); db = done_q.size();
    start_frame();
    cycles(400);
    start_frame();
    wait_done("drop", 1200);
    cycles(50);
    chk("drop_done_count", done_q.size() - db, 1);
    chk("drop_busy_after", bus.busy, 0);
    chk("drop_pulses", widths.size() - wb, 96);

    // vsync rise seen on the frame_done edge is dropped
    start_frame();
    k = 0;
    while (!(m_active && m_n == L - 1) && k < 1200) begin
      @(negedge clk_pixel);
      k++;
    end
    chk("edge_drop_reached", (m_active && m_n == L - 1) ? 1 : 0, 1);
    bus.frame_vsync = 1'b1;
    cycles(20);
    chk("edge_drop_busy", bus.busy, 0);
    bus.frame_vsync = 1'b0;
    cycles(2);

    // vsync rise seen on the edge after frame_done is accepted
    start_frame();
    k = 0;
    while (bus.frame_done !== 1'b1 && k < 1200) begin
      @(negedge clk_pixel);
      k++;
    end
    chk("edge_accept_reached", bus.frame_done, 1);
    bus.frame_vsync = 1'b1;
    cycles(1);
    chk("edge_accept_busy", bus.busy, 1);
    cycles(2);
    bus.frame_vsync = 1'b0;
    wait_done("edge_accept", 1200);
    cycles(3);

    // reset during a HIGH phase
    rand_fb(fa);
    bus.framebuffer = fa;
    start_frame();
    k = 0;
    while (bus.led_dout !== 1'b1 && k < 200) begin
      @(negedge clk_pixel);
      k++;
    end
    chk("rst_mid_high_seen", bus.led_dout, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_led", bus.led_dout, 0);
    chk("rst_mid_busy", bus.busy, 0);
    cycles(3);
    rst_n = 1'b1;
    cycles(5);
    rand_fb(fa);
    bus.framebuffer = fa;
    wb = widths.size(); db = done_q.size();
    start_frame();
    wait_done("rst_mid", 1200);
    cycles(5);
    chk("rst_mid_pulses", widths.size() - wb, 96);
    chk("rst_mid_done_count", done_q.size() - db, 1);

    // randomized vsync toggling and framebuffer churn
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk_pixel);
      if ($urandom_range(0, 149) == 0) bus.frame_vsync = ~bus.frame_vsync;
      if ($urandom_range(0, 299) == 0) begin
        rand_fb(fa);
        bus.framebuffer = fa;
      end
    end
    bus.frame_vsync = 1'b0;
    cycles(1200);
    chk("final_idle_busy", bus.busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
